// File: rtl/shifter_operand_encoder.sv
// Encodes a 32-bit constant as an ARM-style shifter operand.
// Data-processing mode: one rotation candidate is tested per cycle, smallest rotation wins.
// Load/store mode: single-cycle test for a 12-bit unsigned offset.
// Optional macro ENC_INVERT_EN: after a failed rotation search, a second pass runs on ~value.
module shifter_operand_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        ls_mode,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [11:0] shift_operand,
  output logic        inverted
);

  localparam int unsigned VAL_W = 32;
  localparam int unsigned OP_W  = 12;
  localparam int unsigned ROT_W = 4;
  localparam int unsigned IMM_W = 8;
  localparam int unsigned OFS_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [VAL_W-1:0]    value_q, value_d;
  logic                ls_q, ls_d;
  logic [ROT_W-1:0]    r_q, r_d;
  logic                busy_d, done_d, valid_d, inv_d;
  logic [OP_W-1:0]     op_d;

  logic [2*VAL_W-1:0]  dbl;
  logic [VAL_W-1:0]    cand;
  logic                cand_hit;
  logic                ls_hit;
  logic                last_rot;

  // Rotate-left by 2*r: the upper half of the doubled word shifted left.
  assign dbl      = {value_q, value_q} << {r_q, 1'b0};
  assign cand     = dbl[2*VAL_W-1:VAL_W];
  assign cand_hit = (cand[VAL_W-1:IMM_W] == '0);
  assign ls_hit   = (value_q[VAL_W-1:OFS_W] == '0);
  assign last_rot = (r_q == {ROT_W{1'b1}});

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    ls_d    = ls_q;
    r_d     = r_q;
    valid_d = valid;
    op_d    = shift_operand;
    inv_d   = inverted;

    case (state_q)
      IDLE: begin
        if (start) begin
          value_d = value;
          ls_d    = ls_mode;
          r_d     = '0;
          valid_d = 1'b0;
          op_d    = '0;
          inv_d   = 1'b0;
          state_d = SEARCH;
        end
      end

      SEARCH: begin
        if (ls_q) begin
          state_d = DONE;
          if (ls_hit) begin
            valid_d = 1'b1;
            op_d    = value_q[OFS_W-1:0];
          end else begin
            valid_d = 1'b0;
            op_d    = '0;
          end
        end else if (cand_hit) begin
          valid_d = 1'b1;
          op_d    = {r_q, cand[IMM_W-1:0]};
          state_d = DONE;
        end else if (!last_rot) begin
          r_d = r_q + ROT_W'(1);
        end else begin
`ifdef ENC_INVERT_EN
          // The inverted flag doubles as the second-pass marker.
          if (!inverted) begin
            value_d = ~value_q;
            r_d     = '0;
            inv_d   = 1'b1;
          end else begin
            valid_d = 1'b0;
            op_d    = '0;
            inv_d   = 1'b0;
            state_d = DONE;
          end
`else
          valid_d = 1'b0;
          op_d    = '0;
          state_d = DONE;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifndef ENC_INVERT_EN
    inv_d = 1'b0;
`endif

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      value_q       <= '0;
      ls_q          <= 1'b0;
      r_q           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      valid         <= 1'b0;
      shift_operand <= '0;
      inverted      <= 1'b0;
    end else begin
      state_q       <= state_d;
      value_q       <= value_d;
      ls_q          <= ls_d;
      r_q           <= r_d;
      busy          <= busy_d;
      done          <= done_d;
      valid         <= valid_d;
      shift_operand <= op_d;
      inverted      <= inv_d;
    end
  end

endmodule

// File: tb/tb_shifter_operand_encoder.sv
// Self-checking bench for shifter_operand_encoder (honours ENC_INVERT_EN if defined).
module tb_shifter_operand_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        ls_mode;
  logic        busy;
  logic        done;
  logic        valid;
  logic [11:0] shift_operand;
  logic        inverted;

  int n_cmp;
  int n_err;

  shifter_operand_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .value         (value),
    .ls_mode       (ls_mode),
    .busy          (busy),
    .done          (done),
    .valid         (valid),
    .shift_operand (shift_operand),
    .inverted      (inverted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Rotate right one bit at a time.
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [31:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[0], y[31:1]};
    return y;
  endfunction

  // Smallest rotation r with value == ROR(imm8, 2r), or -1.
  function automatic int find_rot(input logic [31:0] v, output logic [7:0] imm);
    logic [31:0] t;
    imm = 8'h00;
    for (int r = 0; r < 16; r++) begin
      t = ror(v, 32 - 2 * r);
      if (t < 32'd256) begin
        imm = t[7:0];
        return r;
      end
    end
    return -1;
  endfunction

  // Reference model: expected result and completion latency (cycles after accept).
  task automatic model(input logic [31:0] v, input logic lm, output logic ev,
                       output logic [11:0] eop, output logic einv, output int elat);
    int r;
    logic [7:0] imm;
    einv = 1'b0;
    if (lm) begin
      ev   = (v < 32'd4096);
      eop  = ev ? v[11:0] : 12'h000;
      elat = 1;
    end else begin
      r = find_rot(v, imm);
      if (r >= 0) begin
        ev = 1'b1; eop = {4'(r), imm}; elat = r + 1;
      end else begin
        ev = 1'b0; eop = 12'h000; elat = 16;
`ifdef ENC_INVERT_EN
        r = find_rot(~v, imm);
        if (r >= 0) begin
          ev = 1'b1; eop = {4'(r), imm}; einv = 1'b1; elat = 16 + r + 1;
        end else begin
          elat = 32;
        end
`endif
      end
    end
  endtask

  // Issue one request and check latency, result, pulse width and hold.
  task automatic do_op(input string tag, input logic [31:0] v, input logic lm,
                       input logic glitch);
    logic        ev, einv;
    logic [11:0] eop;
    int          elat, lat;
    logic [31:0] dec;
    model(v, lm, ev, eop, einv, elat);
    @(negedge clk);
    start = 1'b1; value = v; ls_mode = lm;
    @(posedge clk); #1;
    start = 1'b0; value = $urandom; ls_mode = $urandom_range(0, 1) != 0;
    check({tag, ".busy_acc"}, 32'(busy), 32'd1);
    check({tag, ".valid_clr"}, 32'(valid), 32'd0);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin lat = n; break; end
      if (glitch && n == 2) begin
        start = 1'b1; value = 32'h0000_0001; ls_mode = 1'b1;
      end
    end
    start = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".valid"}, 32'(valid), 32'(ev));
    check({tag, ".operand"}, 32'(shift_operand), 32'(eop));
    check({tag, ".inverted"}, 32'(inverted), 32'(einv));
    if (valid && !lm) begin
      dec = ror({24'd0, shift_operand[7:0]}, 2 * int'(shift_operand[11:8]));
      check({tag, ".decode"}, dec, inverted ? ~v : v);
    end
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".busy_idle"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, ".hold"}, {19'd0, valid, inverted, shift_operand}, {19'd0, ev, einv, eop});
  endtask

  initial begin
    int          sel, dones;
    logic [31:0] v;
    n_cmp = 0; n_err = 0;
    rst = 1'b0; start = 1'b1; value = 32'hFFFF_FFFF; ls_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.outs", {27'd0, busy, done, valid, inverted, 1'b0}, 32'd0);
    check("reset.operand", 32'(shift_operand), 32'd0);
    @(negedge clk); rst = 1'b1; start = 1'b0;

    do_op("imm_ff",    32'h0000_00FF, 1'b0, 1'b0);
    do_op("imm_ff000", 32'hFF00_0000, 1'b0, 1'b0);
    do_op("imm_3f0",   32'h0000_03F0, 1'b0, 1'b0);
    do_op("imm_zero",  32'h0000_0000, 1'b0, 1'b0);
    do_op("imm_102",   32'h0000_0102, 1'b0, 1'b0);
    do_op("imm_ffff00",32'hFFFF_FF00, 1'b0, 1'b0);
    do_op("ls_abc",    32'h0000_0ABC, 1'b1, 1'b0);
    do_op("ls_1000",   32'h0000_1000, 1'b1, 1'b0);
    do_op("ls_fff",    32'h0000_0FFF, 1'b1, 1'b0);
    do_op("glitch",    32'hFF00_0000, 1'b0, 1'b1);

    // Reset while the search sits at r=7.
    @(negedge clk);
    start = 1'b1; value = 32'h0000_0102; ls_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    check("midrst.outs", {27'd0, busy, done, valid, inverted, 1'b0}, 32'd0);
    check("midrst.operand", 32'(shift_operand), 32'd0);
    rst = 1'b1;
    dones = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midrst.no_done", 32'(dones), 32'd0);
    do_op("post_rst", 32'h0000_03F0, 1'b0, 1'b0);

    // Randomized mix of encodable, arbitrary, inverted and offset constants.
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0:       v = ror({24'd0, 8'($urandom)}, 2 * $urandom_range(0, 15));
        1:       v = $urandom;
        2:       v = ~ror({24'd0, 8'($urandom)}, 2 * $urandom_range(0, 15));
        3:       v = 32'($urandom_range(0, 4095));
        default: v = $urandom & 32'h0000_3FFF;
      endcase
      do_op($sformatf("rnd%0d", k), v, sel >= 3, k % 7 == 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
